// File: rtl/approx_sum_checker.sv
// Check-and-recover stage behind the approximate adder: verifies the speculative sum chunk-wise
// in one cycle and, on mismatch, re-adds the operands as a chunk-serial ripple.
//
// state | meaning
// IDLE  | waiting for operands, in_ready_o high
// CHECK | chunk-wise self-consistency test of the captured speculative sum
// FIX   | one chunk of the exact sum per cycle, carry held in cy_q
// DONE  | result held, out_valid_o high until out_ready_i
module approx_sum_checker #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   spec_result_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH:0]   result_o,
    output logic             err_o,
    output logic [15:0]      corr_cnt_o
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, FIX, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic [WIDTH:0]   s_q, result_q;
    logic             err_q, out_valid_q, cy_q;
    logic [KW-1:0]    k_q;
    logic [15:0]      corr_cnt_q;

    logic [N:0]       c_imp;
    logic             chk_pass;
    logic [CHUNK:0]   fix_sum_d;
    logic [WIDTH-1:0] r_d;

    // Carries implied by the sum bits at each chunk base; each chunk must reproduce its slice and
    // the next implied carry, which by induction from c_0 = 0 makes the whole sum exact.
    always_comb begin
        c_imp    = '0;
        chk_pass = 1'b1;
        for (int k = 1; k < N; k++) begin
            c_imp[k] = s_q[k*CHUNK] ^ a_q[k*CHUNK] ^ b_q[k*CHUNK];
        end
        c_imp[N] = s_q[WIDTH];
        for (int k = 0; k < N; k++) begin
            if ((CHUNK+1)'(a_q[k*CHUNK +: CHUNK]) + (CHUNK+1)'(b_q[k*CHUNK +: CHUNK])
                    + (CHUNK+1)'(c_imp[k]) != {c_imp[k+1], s_q[k*CHUNK +: CHUNK]}) begin
                chk_pass = 1'b0;
            end
        end
    end

    always_comb begin
        fix_sum_d = (CHUNK+1)'(a_q[int'(k_q)*CHUNK +: CHUNK])
                  + (CHUNK+1)'(b_q[int'(k_q)*CHUNK +: CHUNK])
                  + (CHUNK+1)'(cy_q);
        r_d = r_q;
        r_d[int'(k_q)*CHUNK +: CHUNK] = fix_sum_d[CHUNK-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            r_q         <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            cy_q        <= 1'b0;
            k_q         <= '0;
            corr_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q     <= add1_i;
                        b_q     <= add2_i;
                        s_q     <= spec_result_i;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (chk_pass) begin
                        result_q    <= s_q;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cy_q    <= 1'b0;
                        k_q     <= '0;
                        r_q     <= '0;
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    r_q  <= r_d;
                    cy_q <= fix_sum_d[CHUNK];
                    k_q  <= k_q + KW'(1);
                    if (k_q == KW'(N-1)) begin
                        result_q    <= {fix_sum_d[CHUNK], r_d};
                        err_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        if (corr_cnt_q != 16'hFFFF) begin
                            corr_cnt_q <= corr_cnt_q + 16'd1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign err_o       = err_q;
    assign corr_cnt_o  = corr_cnt_q;

endmodule
